// File: rtl/vedic_pkg.sv
// Shared constants and the vedic partial-product helpers for the arbitrated
// 8x8 multiplier.
//   VEDIC_MUL_LAT : clock edges from multiplier operands to product
//   VEDIC_OP_W    : operand width
//   VEDIC_PROD_W  : product width
//   vedic2/vedic4 : combinational urdhva-tiryagbhyam partial products
package vedic_pkg;

    localparam int VEDIC_MUL_LAT = 4;
    localparam int VEDIC_OP_W    = 8;
    localparam int VEDIC_PROD_W  = 16;

    // 2x2 vertical-and-crosswise: the cross terms a1b0 + a0b1 carry into the a1b1 column.
    function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] t;
        logic [1:0] u;
        t = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
        u = {1'b0, a[1] & b[1]} + {1'b0, t[1]};
        return {u, t[0], a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ll;
        logic [3:0] lh;
        logic [3:0] hl;
        logic [3:0] hh;
        logic [4:0] mid;
        ll  = vedic2(a[1:0], b[1:0]);
        lh  = vedic2(a[1:0], b[3:2]);
        hl  = vedic2(a[3:2], b[1:0]);
        hh  = vedic2(a[3:2], b[3:2]);
        mid = {1'b0, lh} + {1'b0, hl};
        return {4'b0000, ll} + {1'b0, mid, 2'b00} + {hh, 4'b0000};
    endfunction

endpackage

// File: rtl/vedic_mul_arbiter_if.sv
// Client-side bus of the shared multiplier.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed operands, requester i on [8i+7:8i]
//   rsp_valid/id/prod   : response pulse with owning requester and product
//   busy, issue_cnt     : status
// slave = arbiter side, master = requester side.
interface vedic_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [15:0]        rsp_prod;
    logic               busy;
    logic [15:0]        issue_cnt;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, busy, issue_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_prod, busy, issue_cnt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : highest-priority index this cycle
//   gnt_onehot : one-hot grant (zero when nothing requests)
//   gnt_id     : index of the grant
//   gnt_any    : a grant exists
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_any
);

    // First pass takes the lowest requester at or above ptr; if none, the
    // second pass takes the lowest overall, which is the wrapped-around winner.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        gnt_any    = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!gnt_any && req[j] && (ID_W'(j) >= ptr)) begin
                gnt_any       = 1'b1;
                gnt_onehot[j] = 1'b1;
                gnt_id        = ID_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!gnt_any && req[j]) begin
                gnt_any       = 1'b1;
                gnt_onehot[j] = 1'b1;
                gnt_id        = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/vedic8x8.sv
// Four-stage pipelined 8x8 unsigned vedic multiplier, no enable, no reset.
//   clk  : clock
//   a, b : operands
//   prod : a*b, VEDIC_MUL_LAT rising edges after a/b are presented
module vedic8x8
    import vedic_pkg::*;
(
    input  logic                    clk,
    input  logic [VEDIC_OP_W-1:0]   a,
    input  logic [VEDIC_OP_W-1:0]   b,
    output logic [VEDIC_PROD_W-1:0] prod
);

    logic [7:0]  ll_d, lh_d, hl_d, hh_d;
    logic [7:0]  ll_q, lh_q, hl_q, hh_q;
    logic [7:0]  lo_d, lo_q, hi_d, hi_q;
    logic [8:0]  mid_d, mid_q;
    logic [15:0] sum_d, sum_q, prod_q;

    always_comb begin
        ll_d  = vedic4(a[3:0], b[3:0]);
        lh_d  = vedic4(a[3:0], b[7:4]);
        hl_d  = vedic4(a[7:4], b[3:0]);
        hh_d  = vedic4(a[7:4], b[7:4]);
        lo_d  = ll_q;
        hi_d  = hh_q;
        mid_d = {1'b0, lh_q} + {1'b0, hl_q};
        sum_d = {hi_q, 8'h00} + {3'b000, mid_q, 4'h0} + {8'h00, lo_q};
    end

    always_ff @(posedge clk) begin
        ll_q   <= ll_d;
        lh_q   <= lh_d;
        hl_q   <= hl_d;
        hh_q   <= hh_d;
        lo_q   <= lo_d;
        mid_q  <= mid_d;
        hi_q   <= hi_d;
        sum_q  <= sum_d;
        prod_q <= sum_q;
    end

    assign prod = prod_q;

endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shares one pipelined vedic8x8 among N_REQ requesters. A round-robin grant
// registers the winner's operands into the multiplier; the winner's ID rides a
// tag pipe of matching depth so each product comes back labelled.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vedic_mul_arbiter_if (requests, responses, status)
// MUL_LAT must equal the vedic8x8 pipeline depth.
module vedic_mul_arbiter
    import vedic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = VEDIC_MUL_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    vedic_mul_arbiter_if.slave   bus
);

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [N_REQ-1:0]        gnt_onehot;
    logic [ID_W-1:0]         gnt_id;
    logic                    gnt_any;
    logic                    accept;

    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [VEDIC_OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    tag_t                    issue_tag_q, issue_tag_d;
    tag_t                    pipe_q [MUL_LAT];
    tag_t                    pipe_d [MUL_LAT];
    logic [15:0]             issue_cnt_q, issue_cnt_d;
    logic [VEDIC_PROD_W-1:0] mul_prod;
    logic                    busy_c;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req        (bus.req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .gnt_any    (gnt_any)
    );

    assign accept        = gnt_any & ~rst;
    assign bus.req_ready = rst ? '0 : gnt_onehot;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end

        op_a_d = op_a_q;
        op_b_d = op_b_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                op_a_d = bus.req_a[8*i +: 8];
                op_b_d = bus.req_b[8*i +: 8];
            end
        end

        issue_tag_d.v  = accept;
        issue_tag_d.id = gnt_id;

        pipe_d[0] = issue_tag_q;
        for (int i = 1; i < MUL_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        issue_cnt_d = issue_cnt_q + 16'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            issue_tag_q <= '0;
            issue_cnt_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            issue_tag_q <= issue_tag_d;
            issue_cnt_q <= issue_cnt_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Operand regs feed a reset-less datapath; stale values are masked by the tag.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    vedic8x8 u_mul (
        .clk  (clk),
        .a    (op_a_q),
        .b    (op_b_q),
        .prod (mul_prod)
    );

    always_comb begin
        busy_c = issue_tag_q.v;
        for (int i = 0; i < MUL_LAT; i++) begin
            busy_c = busy_c | pipe_q[i].v;
        end
    end

    // Product is gated so the unreset multiplier never leaks garbage while idle.
    assign bus.rsp_valid = pipe_q[MUL_LAT-1].v;
    assign bus.rsp_id    = pipe_q[MUL_LAT-1].id;
    assign bus.rsp_prod  = pipe_q[MUL_LAT-1].v ? mul_prod : '0;
    assign bus.busy      = busy_c;
    assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Scoreboard bench for vedic_mul_arbiter: an accept monitor predicts grants
// and pushes expected {id, product, cycle}; a response monitor pops and checks.
module tb_vedic_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vedic_mul_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();

    vedic_mul_arbiter #(.N_REQ(N), .ID_W(2), .MUL_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int id;
        int prod;
        int t;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_log[$];
    int   rsp_id_log[$];
    int   rsp_prod_log[$];

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int n_rsp    = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;
    int last_acc = -100;

    logic [N-1:0] acc_mask = '0;
    logic [N-1:0] drv_v;
    logic [7:0]   drv_a [N];
    logic [7:0]   drv_b [N];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Accept monitor: independent round-robin prediction and scoreboard push.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (rst) begin
            chk("rst_req_ready", int'(bus.req_ready), 0);
            chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
            chk("rst_rsp_id", int'(bus.rsp_id), 0);
            chk("rst_rsp_prod", int'(bus.rsp_prod), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_issue_cnt", int'(bus.issue_cnt), 0);
            sb_q.delete();
            m_ptr    = 0;
            m_cnt    = 0;
            last_acc = -100;
            acc_mask = '0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && bus.req_valid[j]) g = j;
            end
            exp_rdy = (g < 0) ? '0 : (N'(1) << g);
            chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
            chk("issue_cnt", int'(bus.issue_cnt), m_cnt);
            chk("busy", int'(bus.busy), int'((cyc - last_acc >= 1) && (cyc - last_acc <= LAT)));
            acc_mask = bus.req_valid & bus.req_ready;
            if (g >= 0) begin
                exp_t e;
                e.id   = g;
                e.prod = int'(bus.req_a[8*g +: 8]) * int'(bus.req_b[8*g +: 8]);
                e.t    = cyc;
                sb_q.push_back(e);
                gnt_log.push_back(g);
                m_ptr    = (g + 1) % N;
                m_cnt    = (m_cnt + 1) & 16'hFFFF;
                last_acc = cyc;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            n_rsp++;
            rsp_id_log.push_back(int'(bus.rsp_id));
            rsp_prod_log.push_back(int'(bus.rsp_prod));
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got id %0d prod 0x%0h, expected no response (cycle %0d)",
                         bus.rsp_id, bus.rsp_prod, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_id", int'(bus.rsp_id), e.id);
                chk("rsp_prod", int'(bus.rsp_prod), e.prod);
                chk("rsp_latency", cyc - e.t, LAT);
            end
        end
    end

    task automatic apply();
        bus.req_valid = drv_v;
        for (int i = 0; i < N; i++) begin
            bus.req_a[8*i +: 8] = drv_a[i];
            bus.req_b[8*i +: 8] = drv_b[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int i, input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!acc_mask[i] && k < 20);
        chk(name, int'(acc_mask[i]), 1);
    endtask

    function automatic int last_of(input int q[$]);
        return (q.size() == 0) ? -1 : q[q.size()-1];
    endfunction

    int exp_g3[8]    = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_p3[8]    = '{'h000, 'h044, 'h0AA, 'h132, 'h000, 'h044, 'h0AA, 'h132};
    int exp_g4[4]    = '{3, 1, 3, 1};
    int rsp_before;

    initial begin
        // 1: reset with every requester asserting
        drv_v = '1;
        for (int i = 0; i < N; i++) begin
            drv_a[i] = 8'(i + 1);
            drv_b[i] = 8'(2 * i + 1);
        end
        apply();
        rst = 1'b1;
        repeat (3) tick();
        chk("t1_ready_in_reset", int'(bus.req_ready), 0);
        chk("t1_busy_in_reset", int'(bus.busy), 0);
        gnt_log.delete();
        rst = 1'b0;
        tick();
        chk("t1_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        drv_v = '0;
        apply();
        repeat (8) tick();

        // 2: single 0xFF*0xFF from requester 2
        drv_a[2] = 8'hFF;
        drv_b[2] = 8'hFF;
        drv_v    = 4'b0100;
        apply();
        rsp_before = n_rsp;
        wait_acc(2, "t2_accept_timeout");
        drv_v = '0;
        apply();
        repeat (8) tick();
        chk("t2_rsp_count", n_rsp - rsp_before, 1);
        chk("t2_rsp_id", last_of(rsp_id_log), 2);
        chk("t2_rsp_prod", last_of(rsp_prod_log), 'hFE01);

        // 3: full contention after reset
        pulse_reset(2);
        for (int i = 0; i < N; i++) begin
            drv_a[i] = 8'(i + 3);
            drv_b[i] = 8'(8'h11 * i);
        end
        drv_v = '1;
        apply();
        gnt_log.delete();
        rsp_id_log.delete();
        rsp_prod_log.delete();
        repeat (8) tick();
        drv_v = '0;
        apply();
        repeat (8) tick();
        chk("t3_grant_count", gnt_log.size(), 8);
        chk("t3_rsp_count", rsp_id_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) chk($sformatf("t3_grant%0d", i), gnt_log[i], exp_g3[i]);
            if (i < rsp_id_log.size()) begin
                chk($sformatf("t3_rsp_id%0d", i), rsp_id_log[i], exp_g3[i]);
                chk($sformatf("t3_rsp_prod%0d", i), rsp_prod_log[i], exp_p3[i]);
            end
        end
        chk("t3_issue_cnt", int'(bus.issue_cnt), 8);

        // 4: sparse requesters 1 and 3 with pointer parked at 2
        pulse_reset(2);
        drv_v = 4'b0010;
        apply();
        wait_acc(1, "t4_accept_timeout");
        drv_v = 4'b1010;
        apply();
        gnt_log.delete();
        repeat (4) tick();
        drv_v = '0;
        apply();
        repeat (8) tick();
        chk("t4_grant_count", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_log.size()) chk($sformatf("t4_grant%0d", i), gnt_log[i], exp_g4[i]);
        end

        // 5: reset while three ops are in flight
        pulse_reset(2);
        for (int i = 0; i < N; i++) begin
            drv_a[i] = 8'(8'h20 + i);
            drv_b[i] = 8'(8'h30 + i);
        end
        drv_v = '1;
        apply();
        repeat (3) tick();
        drv_v = '0;
        apply();
        repeat (2) tick();
        chk("t5_busy_before_reset", int'(bus.busy), 1);
        rsp_before = n_rsp;
        pulse_reset(2);
        chk("t5_busy_after_reset", int'(bus.busy), 0);
        chk("t5_issue_cnt_after_reset", int'(bus.issue_cnt), 0);
        repeat (10) tick();
        chk("t5_no_rsp", n_rsp - rsp_before, 0);

        // 6: random traffic honouring hold-until-granted
        for (int n = 0; n < 10000; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!drv_v[i] || acc_mask[i]) begin
                    drv_v[i] = 1'($urandom_range(0, 1));
                    drv_a[i] = 8'($urandom);
                    drv_b[i] = 8'($urandom);
                end
            end
            apply();
        end
        drv_v = '0;
        apply();
        repeat (10) tick();
        chk("t6_scoreboard_empty", sb_q.size(), 0);
        chk("t6_busy_idle", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
